// File: rtl/tt_vector_player_pkg.sv
// rtl/tt_vector_player_pkg.sv - shared types and helpers for the vector player.
package tt_vector_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vp_state_e;

  localparam int unsigned VP_IN_W  = 8;
  localparam int unsigned VP_OUT_W = 8;
  localparam int unsigned VP_DEPTH = 16;
  localparam int unsigned IDX_W    = $clog2(VP_DEPTH) + 1;

  typedef struct packed {
    logic [VP_IN_W-1:0]  stim;
    logic [VP_OUT_W-1:0] exp;
    logic [VP_OUT_W-1:0] mask;
  } vp_entry_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tt_vp_delay_line.sv
// rtl/tt_vp_delay_line.sv - LATENCY-deep pipeline carrying compare metadata to the check point.
module tt_vp_delay_line #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = 4,
  parameter int unsigned OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [AW-1:0]    in_idx,
  input  logic [OUT_W-1:0] in_exp,
  input  logic [OUT_W-1:0] in_mask,
  output logic             out_valid,
  output logic [AW-1:0]    out_idx,
  output logic [OUT_W-1:0] out_exp,
  output logic [OUT_W-1:0] out_mask
);

  localparam int unsigned W = 1 + AW + 2 * OUT_W;

  logic [W-1:0] stage_q [LATENCY];
  logic [W-1:0] stage_d [LATENCY];

  always_comb begin
    stage_d[0] = {in_valid, in_idx, in_exp, in_mask};
    for (int i = 1; i < int'(LATENCY); i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign {out_valid, out_idx, out_exp, out_mask} = stage_q[LATENCY-1];

endmodule

// File: rtl/tt_vector_player.sv
// rtl/tt_vector_player.sv - vector table sequencer: plays stimulus, checks masked DUT response.
// Define TT_VECTOR_PLAYER_CAPTURE_EN to add first_err_data/last_data capture ports.
module tt_vector_player
  import tt_vector_player_pkg::*;
#(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [IN_W-1:0]          load_stim,
  input  logic [OUT_W-1:0]         load_exp,
  input  logic [OUT_W-1:0]         load_mask,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     clear,
  output logic [IN_W-1:0]          dut_in,
  input  logic [OUT_W-1:0]         dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         err_count,
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
  output logic [OUT_W-1:0]         first_err_data,
  output logic [OUT_W-1:0]         last_data,
`endif
  output logic [$clog2(DEPTH)-1:0] first_err_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = idx_w(DEPTH);

  typedef struct packed {
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] exp;
    logic [OUT_W-1:0] mask;
  } entry_t;

  entry_t tbl_q [DEPTH];
  entry_t cur;

  vp_state_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic             iss_valid_q, iss_valid_d;
  logic [AW-1:0]    iss_idx_q, iss_idx_d;
  logic [OUT_W-1:0] iss_exp_q, iss_exp_d;
  logic [OUT_W-1:0] iss_mask_q, iss_mask_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [AW-1:0]    fidx_q, fidx_d;
  logic             aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             load_ready_q, load_ready_d;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
  logic [OUT_W-1:0] fdata_q, fdata_d;
  logic [OUT_W-1:0] ldata_q, ldata_d;
`endif

  logic             dl_valid;
  logic [AW-1:0]    dl_idx;
  logic [OUT_W-1:0] dl_exp, dl_mask;
  logic             wr_en, start_go, abort_hit, flush, cmp_en, mismatch;
  logic             run_last, drain_last;

  assign cur        = tbl_q[rp_q];
  assign wr_en      = (state_q == IDLE) && load_valid && (count_q < CW'(DEPTH));
  assign abort_hit  = abort && !clear && ((state_q == RUN) || (state_q == DRAIN));
  assign start_go   = start && !clear && !abort &&
                      (((state_q == IDLE) && (count_q != '0)) || (state_q == DONE));
  assign flush      = clear || abort_hit;
  // The compare landing on an abort/clear edge belongs to a discarded run.
  assign cmp_en     = dl_valid && !flush;
  assign mismatch   = cmp_en && (|((dut_out ^ dl_exp) & dl_mask));
  assign run_last   = (CW'(rp_q) == (count_q - CW'(1)));
  assign drain_last = dl_valid && (dl_idx == AW'(count_q - CW'(1)));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_q[count_q[AW-1:0]] <= {load_stim, load_exp, load_mask};
    end
  end

  tt_vp_delay_line #(
    .LATENCY (LATENCY),
    .AW      (AW),
    .OUT_W   (OUT_W)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (iss_valid_q),
    .in_idx    (iss_idx_q),
    .in_exp    (iss_exp_q),
    .in_mask   (iss_mask_q),
    .out_valid (dl_valid),
    .out_idx   (dl_idx),
    .out_exp   (dl_exp),
    .out_mask  (dl_mask)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rp_d        = rp_q;
    dut_in_d    = dut_in_q;
    iss_valid_d = 1'b0;
    iss_idx_d   = iss_idx_q;
    iss_exp_d   = iss_exp_q;
    iss_mask_d  = iss_mask_q;
    err_d       = err_q;
    fidx_d      = fidx_q;
    aborted_d   = aborted_q;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
    fdata_d     = fdata_q;
    ldata_d     = cmp_en ? dut_out : ldata_q;
`endif

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + CNT_W'(1);
      if (err_q == '0) begin
        fidx_d = dl_idx;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
        fdata_d = dut_out;
`endif
      end
    end

    unique case (state_q)
      IDLE: begin
        if (wr_en) count_d = count_q + CW'(1);
      end
      RUN: begin
        dut_in_d    = cur.stim;
        iss_valid_d = 1'b1;
        iss_idx_d   = rp_q;
        iss_exp_d   = cur.exp;
        iss_mask_d  = cur.mask;
        rp_d        = rp_q + AW'(1);
        if (run_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last) state_d = DONE;
      end
      default: ;
    endcase

    if (start_go) begin
      state_d = RUN;
      rp_d    = '0;
    end
    if (abort_hit) begin
      state_d     = DONE;
      aborted_d   = 1'b1;
      dut_in_d    = dut_in_q;
      iss_valid_d = 1'b0;
    end
    if (clear) begin
      state_d     = IDLE;
      count_d     = '0;
      rp_d        = '0;
      dut_in_d    = dut_in_q;
      iss_valid_d = 1'b0;
    end
    if (start_go || clear) begin
      err_d     = '0;
      fidx_d    = '0;
      aborted_d = 1'b0;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
      fdata_d   = '0;
      ldata_d   = '0;
`endif
    end

    busy_d       = (state_d == RUN) || (state_d == DRAIN);
    done_d       = (state_d == DONE);
    pass_d       = done_d && (err_d == '0) && !aborted_d;
    load_ready_d = (state_d == IDLE) && (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rp_q         <= '0;
      dut_in_q     <= '0;
      iss_valid_q  <= 1'b0;
      iss_idx_q    <= '0;
      iss_exp_q    <= '0;
      iss_mask_q   <= '0;
      err_q        <= '0;
      fidx_q       <= '0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
      fdata_q      <= '0;
      ldata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rp_q         <= rp_d;
      dut_in_q     <= dut_in_d;
      iss_valid_q  <= iss_valid_d;
      iss_idx_q    <= iss_idx_d;
      iss_exp_q    <= iss_exp_d;
      iss_mask_q   <= iss_mask_d;
      err_q        <= err_d;
      fidx_q       <= fidx_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      load_ready_q <= load_ready_d;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
      fdata_q      <= fdata_d;
      ldata_q      <= ldata_d;
`endif
    end
  end

  assign load_ready    = load_ready_q;
  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
  assign first_err_data = fdata_q;
  assign last_data      = ldata_q;
`endif

endmodule

// File: tb/tb_tt_vector_player.sv
// tb/tb_tt_vector_player.sv - directed self-checking bench for tt_vector_player.
module tb_tt_vector_player;
  import tt_vector_player_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       load_valid, load_ready, start, abort, clear, busy, done, pass;
  logic [7:0] load_stim, load_exp, load_mask, dut_in, dut_out, err_count;
  logic [3:0] first_err_idx;
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
  logic [7:0] first_err_data, last_data, b_fdata, b_ldata;
`endif

  logic       b_load_valid, b_load_ready, b_start, b_abort, b_clear, b_busy, b_done, b_pass;
  logic [7:0] b_load_stim, b_load_exp, b_load_mask, b_dut_in, b_dut_out, b_err;
  logic [8:0] b_fidx;
  logic [7:0] bp1, bp2;

  int checks = 0;
  int failures = 0;
  int model_mode = 0;

  tt_vector_player u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .start(start), .abort(abort), .clear(clear), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
    .first_err_data(first_err_data), .last_data(last_data),
`endif
    .first_err_idx(first_err_idx)
  );

  tt_vector_player #(.DEPTH(512), .LATENCY(3), .CNT_W(8)) u_big (
    .clk(clk), .rst(rst), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_stim(b_load_stim), .load_exp(b_load_exp), .load_mask(b_load_mask),
    .start(b_start), .abort(b_abort), .clear(b_clear), .dut_in(b_dut_in), .dut_out(b_dut_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
    .first_err_data(b_fdata), .last_data(b_ldata),
`endif
    .first_err_idx(b_fidx)
  );

  // Registered DUT stand-in (out = in + 1) with selectable corruptions.
  function automatic logic [7:0] model_f(input logic [7:0] x, input int mode);
    logic [7:0] y;
    y = x + 8'd1;
    if (mode == 1 && x == 8'h03) y = 8'h00;
    if (mode == 2 && x == 8'h02) y = y ^ 8'hF0;
    if (mode == 3 && x == 8'h02) y = 8'h00;
    return y;
  endfunction

  always @(posedge clk) dut_out <= model_f(dut_in, model_mode);

  always @(posedge clk) begin
    bp1       <= b_dut_in + 8'd1;
    bp2       <= bp1;
    b_dut_out <= bp2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic vp_entry_t mk(input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
    vp_entry_t v;
    v.stim = s;
    v.exp  = e;
    v.mask = m;
    return v;
  endfunction

  task automatic load_vec(input vp_entry_t v);
    load_valid = 1'b1;
    load_stim  = v.stim;
    load_exp   = v.exp;
    load_mask  = v.mask;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    rst = 1'b1;
    load_valid = 0; load_stim = 0; load_exp = 0; load_mask = 0;
    start = 0; abort = 0; clear = 0;
    b_load_valid = 0; b_load_stim = 0; b_load_exp = 0; b_load_mask = 0;
    b_start = 0; b_abort = 0; b_clear = 0;
    tick();
    tick();
    check("rst_load_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fidx", first_err_idx, 0);
    check("rst_dut_in", dut_in, 0);
    rst = 1'b0;
    tick();

    // Clean run: 4 vectors, out = in + 1.
    for (int i = 0; i < 4; i++) load_vec(mk(8'(i + 1), 8'(i + 2), 8'hFF));
    check("t1_ready", load_ready, 1);
    do_start();
    check("t1_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t1_dut_in_%0d", k), dut_in, k + 1);
    end
    tick();
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_busy_end", busy, 0);

    // Replay from DONE with vector 2 corrupted to 0x00.
    model_mode = 1;
    do_start();
    repeat (6) tick();
    check("t2_done", done, 1);
    check("t2_err", err_count, 1);
    check("t2_fidx", first_err_idx, 2);
    check("t2_pass", pass, 0);
`ifdef TT_VECTOR_PLAYER_CAPTURE_EN
    check("t2_fdata", first_err_data, 8'h00);
    check("t2_ldata", last_data, 8'h05);
`endif

    // Vector 1 masked to low nibble; DUT flips only bits 7:4.
    do_clear();
    check("t3_clear_ready", load_ready, 1);
    check("t3_clear_done", done, 0);
    model_mode = 2;
    for (int i = 0; i < 4; i++) load_vec(mk(8'(i + 1), 8'(i + 2), (i == 1) ? 8'h0F : 8'hFF));
    do_start();
    repeat (6) tick();
    check("t3_done", done, 1);
    check("t3_err", err_count, 0);
    check("t3_pass", pass, 1);

    // Over-fill: 18 writes, only 16 accepted.
    do_clear();
    model_mode = 0;
    for (int i = 0; i < 18; i++) begin
      s = (i < 16) ? 8'(i) : ((i == 16) ? 8'hAA : 8'hBB);
      if (i == 16) check("t4_full_ready", load_ready, 0);
      load_vec(mk(s, s + 8'd1, 8'hFF));
    end
    check("t4_full_ready_end", load_ready, 0);
    do_start();
    tick();
    check("t4_first_vec", dut_in, 8'h00);
    repeat (15) tick();
    check("t4_last_vec", dut_in, 8'h0F);
    tick();
    check("t4_done_early", done, 0);
    tick();
    check("t4_done", done, 1);
    check("t4_pass", pass, 1);
    check("t4_err", err_count, 0);

    // Abort at vector 5 after one mismatch on vector 1.
    do_clear();
    model_mode = 3;
    for (int i = 0; i < 8; i++) load_vec(mk(8'(i + 1), 8'(i + 2), 8'hFF));
    do_start();
    repeat (6) tick();
    check("t5_dut_in_v5", dut_in, 8'h06);
    check("t5_err_pre", err_count, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_pass", pass, 0);
    check("t5_err", err_count, 1);
    check("t5_fidx", first_err_idx, 1);
    tick();
    tick();
    check("t5_err_hold", err_count, 1);
    check("t5_dut_in_hold", dut_in, 8'h06);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("t5_cs_done", done, 0);
    check("t5_cs_busy", busy, 0);
    check("t5_cs_err", err_count, 0);
    check("t5_cs_ready", load_ready, 1);
    tick();
    check("t5_cs_idle", busy, 0);
    do_start();
    check("t5_empty_start", busy, 0);

    // Asynchronous reset during DRAIN.
    model_mode = 0;
    load_vec(mk(8'h11, 8'h12, 8'hFF));
    load_vec(mk(8'h22, 8'h23, 8'hFF));
    do_start();
    tick();
    tick();
    check("t6_drain_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_dut_in", dut_in, 0);
    check("t6_rst_ready", load_ready, 1);
    check("t6_rst_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Saturation: 300 forced mismatches at DEPTH=512, LATENCY=3.
    for (int i = 0; i < 300; i++) begin
      b_load_valid = 1'b1;
      b_load_stim  = 8'(i);
      b_load_exp   = 8'(i) + 8'd2;
      b_load_mask  = 8'hFF;
      tick();
    end
    b_load_valid = 1'b0;
    check("t7_ready", b_load_ready, 1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (303) tick();
    check("t7_done_early", b_done, 0);
    tick();
    check("t7_done", b_done, 1);
    check("t7_err_sat", b_err, 8'd255);
    check("t7_pass", b_pass, 0);
    check("t7_fidx", b_fidx, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
